alien_shot_scheduler: RTL

// Paces enemy fire in the invaders game. Counts down a frame-based cooldown, then

---
 rtl/alien_shot_scheduler_pkg.sv | 17 +
 rtl/alien_shot_scheduler_col_scan_wrap.sv | 41 ++++
 rtl/alien_shot_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alien_shot_scheduler_pkg.sv
// Shared types and defaults for the enemy-fire scheduler.
package alien_shot_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SAMPLE,
        SCAN,
        FIRE
    } sched_state_t;

    localparam int NUM_COLS_DEF    = 10;
    localparam int MIN_GAP_DEF     = 30;
    localparam int SIZE_BITS_DEF   = 8;
    localparam int JITTER_BITS_DEF = 4;

endpackage

// File: rtl/alien_shot_scheduler_col_scan_wrap.sv
// Wrap-around column scanner: loads a start column, advances one column per step,
// and reports whether the current column is alive and whether it is the last candidate.
module alien_shot_scheduler_col_scan_wrap #(
    parameter int NUM_COLS = 10,
    parameter int COL_BITS = $clog2(NUM_COLS),
    parameter int TRY_BITS = $clog2(NUM_COLS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [COL_BITS-1:0] start,
    input  logic                step,
    input  logic [NUM_COLS-1:0] mask,
    output logic [COL_BITS-1:0] idx,
    output logic                found,
    output logic                exhausted
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(NUM_COLS - 1);
    localparam logic [TRY_BITS-1:0] LAST_TRY = TRY_BITS'(NUM_COLS - 1);

    logic [TRY_BITS-1:0] tries;

    // mask is sampled live so a column dying mid-scan is skipped
    assign found     = mask[idx];
    assign exhausted = (tries == LAST_TRY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            tries <= '0;
        end else if (load) begin
            idx   <= start;
            tries <= '0;
        end else if (step) begin
            idx   <= (idx == LAST_COL) ? '0 : idx + 1'b1;
            tries <= tries + 1'b1;
        end
    end

endmodule

// File: rtl/alien_shot_scheduler.sv
// Enemy-fire pacing: frame cooldown, random column/jitter pick, wrap scan of live
// columns, and a req/ack handshake to the bomb unit.
module alien_shot_scheduler
    import alien_shot_scheduler_pkg::*;
#(
    parameter  int SIZE_BITS      = SIZE_BITS_DEF,
    parameter  int NUM_COLS       = NUM_COLS_DEF,
    parameter  int MIN_GAP_FRAMES = MIN_GAP_DEF,
    parameter  int JITTER_BITS    = JITTER_BITS_DEF,
    localparam int COL_BITS       = $clog2(NUM_COLS),
    localparam int CNT_W          = $clog2(MIN_GAP_FRAMES + 2**JITTER_BITS) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 frame_tick,
    input  logic [NUM_COLS-1:0]  alive_cols,
    input  logic [SIZE_BITS-1:0] rand_val,
    output logic                 rand_rise,
    output logic                 fire_req,
    output logic [COL_BITS-1:0]  fire_col,
    input  logic                 fire_ack
);

    localparam int                 COL_EXT  = COL_BITS + 1;
    localparam logic [COL_EXT-1:0] COLS_EXT = COL_EXT'(NUM_COLS);
    localparam logic [CNT_W-1:0]   GAP      = CNT_W'(MIN_GAP_FRAMES);

    sched_state_t           state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic [JITTER_BITS-1:0] jit;
    logic [COL_BITS-1:0]    idx;
    logic [COL_BITS-1:0]    start_col;
    logic [COL_EXT-1:0]     raw_ext;
    logic                   found, exhausted;
    logic                   load, step, hit, reload, dec;

    // raw column is below 2*NUM_COLS, so one conditional subtract folds it into range
    assign raw_ext   = {1'b0, rand_val[COL_BITS-1:0]};
    assign start_col = (raw_ext >= COLS_EXT) ? COL_BITS'(raw_ext - COLS_EXT)
                                             : rand_val[COL_BITS-1:0];

    alien_shot_scheduler_col_scan_wrap #(
        .NUM_COLS (NUM_COLS),
        .COL_BITS (COL_BITS)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .start     (start_col),
        .step      (step),
        .mask      (alive_cols),
        .idx       (idx),
        .found     (found),
        .exhausted (exhausted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        hit        = 1'b0;
        reload     = 1'b0;
        dec        = 1'b0;
        if (!enable) begin
            // abort mid-decision still charges a full cooldown
            state_next = IDLE;
            reload     = (state == SCAN) || (state == FIRE);
        end else begin
            case (state)
                IDLE: begin
                    if (cnt == '0)      state_next = REQ;
                    else if (frame_tick) dec = 1'b1;
                end
                REQ:    state_next = SAMPLE;
                SAMPLE: begin
                    load       = 1'b1;
                    state_next = SCAN;
                end
                SCAN: begin
                    if (found) begin
                        hit        = 1'b1;
                        state_next = FIRE;
                    end else begin
                        step = 1'b1;
                        if (exhausted) begin
                            reload     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                FIRE: begin
                    if (fire_ack) begin
                        reload     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= GAP;
            jit       <= '0;
            rand_rise <= 1'b0;
            fire_req  <= 1'b0;
            fire_col  <= '0;
        end else begin
            rand_rise <= (state_next == REQ);
            fire_req  <= (state_next == FIRE);
            if (load)        jit <= rand_val[SIZE_BITS-1 -: JITTER_BITS];
            if (reload)      cnt <= GAP + CNT_W'(jit);
            else if (dec)    cnt <= cnt - 1'b1;
            if (hit)         fire_col <= idx;
        end
    end

endmodule
